// File: rtl/stream_mux_rr.sv
// N-input valid/ready stream mux with round-robin or forced-select arbitration
// feeding a registered one-entry output stage that tags each word with its source.
module stream_mux_rr #(
   parameter int DATA_WIDTH = 11,
   parameter int NUM_INPUTS = 4,
   parameter int SEL_WIDTH  = $clog2(NUM_INPUTS)
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data,
   input  logic [NUM_INPUTS-1:0]            in_valid,
   output logic [NUM_INPUTS-1:0]            in_ready,
   input  logic                             mode,
   input  logic [SEL_WIDTH-1:0]             force_sel,
   output logic [DATA_WIDTH-1:0]            out_data,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [SEL_WIDTH-1:0]             out_src
);

   logic [SEL_WIDTH-1:0] last_grant;
   logic [SEL_WIDTH-1:0] rr_idx;
   logic                 rr_found;
   logic [SEL_WIDTH-1:0] cand;
   logic [SEL_WIDTH-1:0] grant;
   logic                 grant_ok;
   logic                 can_load;
   logic                 load;

   // Round-robin search starts one past the last grant and wraps modulo NUM_INPUTS,
   // so indices >= NUM_INPUTS are never produced.
   always_comb begin
      rr_found = 1'b0;
      rr_idx   = '0;
      cand     = '0;
      for (int k = 1; k <= NUM_INPUTS; k++) begin
         cand = SEL_WIDTH'((int'(last_grant) + k) % NUM_INPUTS);
         if (!rr_found && in_valid[cand]) begin
            rr_found = 1'b1;
            rr_idx   = cand;
         end
      end
   end

   always_comb begin
      grant    = '0;
      grant_ok = 1'b0;
      if (mode) begin
         if (int'(force_sel) < NUM_INPUTS && in_valid[force_sel]) begin
            grant    = force_sel;
            grant_ok = 1'b1;
         end
      end else begin
         grant    = rr_idx;
         grant_ok = rr_found;
      end
   end

   assign can_load = !out_valid || out_ready;
   assign load     = grant_ok && can_load && !reset;

   // Handshake: a channel's word transfers on a rising edge where its in_valid and
   // in_ready are both 1; the output word transfers where out_valid and out_ready are both 1.
   always_comb begin
      in_ready = '0;
      if (load) in_ready[grant] = 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_data   <= '0;
         out_src    <= '0;
         out_valid  <= 1'b0;
         last_grant <= SEL_WIDTH'(NUM_INPUTS - 1);
      end else if (load) begin
         out_data   <= in_data[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
         out_src    <= grant;
         out_valid  <= 1'b1;
         last_grant <= grant;
      end else if (out_ready) begin
         out_valid  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr: a 4-input instance for reset, fairness,
// backpressure, forced select and mid-run reset, plus a 3-input instance for out-of-range select.
module tb_stream_mux_rr;

   localparam int DW = 11;

   logic          clk = 1'b0;
   logic          reset;

   logic [4*DW-1:0] in_data;
   logic [3:0]      in_valid;
   logic [3:0]      in_ready;
   logic            mode;
   logic [1:0]      force_sel;
   logic [DW-1:0]   out_data;
   logic            out_valid;
   logic            out_ready;
   logic [1:0]      out_src;

   logic [3*DW-1:0] in_data3;
   logic [2:0]      in_valid3;
   logic [2:0]      in_ready3;
   logic            mode3;
   logic [1:0]      force_sel3;
   logic [DW-1:0]   out_data3;
   logic            out_valid3;
   logic            out_ready3;
   logic [1:0]      out_src3;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   stream_mux_rr #(.DATA_WIDTH(DW), .NUM_INPUTS(4)) dut (
      .clk(clk), .reset(reset),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .mode(mode), .force_sel(force_sel),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_src(out_src)
   );

   stream_mux_rr #(.DATA_WIDTH(DW), .NUM_INPUTS(3)) dut3 (
      .clk(clk), .reset(reset),
      .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
      .mode(mode3), .force_sel(force_sel3),
      .out_data(out_data3), .out_valid(out_valid3), .out_ready(out_ready3), .out_src(out_src3)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset      = 1'b1;
      mode       = 1'b0;
      force_sel  = 2'd0;
      out_ready  = 1'b1;
      in_valid   = 4'hF;
      for (int i = 0; i < 4; i++) in_data[i*DW +: DW] = DW'(8'h10 + i);
      mode3      = 1'b0;
      force_sel3 = 2'd0;
      out_ready3 = 1'b1;
      in_valid3  = 3'b000;
      for (int i = 0; i < 3; i++) in_data3[i*DW +: DW] = DW'(8'h20 + i);

      // Reset with all channels requesting
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data",  32'(out_data),  32'd0);
      check("rst_out_src",   32'(out_src),   32'd0);
      check("rst_in_ready",  32'(in_ready),  32'd0);

      @(negedge clk);
      reset = 1'b0;
      #1;
      check("post_rst_in_ready", 32'(in_ready), 32'h1);

      // Round-robin fairness: 0,1,2,3,0
      for (int i = 0; i < 5; i++) begin
         step();
         check("rr_src",   32'(out_src),   32'(i % 4));
         check("rr_data",  32'(out_data),  32'h10 + 32'(i % 4));
         check("rr_valid", 32'(out_valid), 32'd1);
      end

      // Drain to empty, then load 0x2A from channel 1
      in_valid = 4'h0;
      step();
      check("drain_valid", 32'(out_valid), 32'd0);
      check("drain_data_hold", 32'(out_data), 32'h10);
      in_data[1*DW +: DW] = DW'(11'h2A);
      in_valid = 4'b0010;
      step();
      check("bp_load_data", 32'(out_data), 32'h2A);
      check("bp_load_src",  32'(out_src),  32'd1);

      // Backpressure for 3 cycles
      out_ready = 1'b0;
      in_valid  = 4'hF;
      #1;
      check("bp_in_ready", 32'(in_ready), 32'd0);
      for (int i = 0; i < 3; i++) begin
         step();
         check("bp_hold_data",  32'(out_data),  32'h2A);
         check("bp_hold_valid", 32'(out_valid), 32'd1);
         check("bp_hold_ready", 32'(in_ready),  32'd0);
      end
      out_ready = 1'b1;
      #1;
      check("bp_release_ready", 32'(in_ready), 32'b0100);
      step();
      check("bp_release_data",  32'(out_data),  32'h12);
      check("bp_release_valid", 32'(out_valid), 32'd1);
      in_data[1*DW +: DW] = DW'(11'h11);

      // Forced select to channel 2, then to channel 1
      mode      = 1'b1;
      force_sel = 2'd2;
      #1;
      check("force2_ready", 32'(in_ready), 32'b0100);
      for (int i = 0; i < 3; i++) begin
         step();
         check("force2_src",  32'(out_src),  32'd2);
         check("force2_data", 32'(out_data), 32'h12);
      end
      in_valid = 4'b1011;
      #1;
      check("force2_invalid_ready", 32'(in_ready), 32'd0);
      in_valid  = 4'hF;
      force_sel = 2'd1;
      #1;
      check("force1_ready", 32'(in_ready), 32'b0010);
      step();
      check("force1_src",  32'(out_src),  32'd1);
      check("force1_data", 32'(out_data), 32'h11);

      // Back to round-robin: last grant was 1, so channel 2 next
      mode = 1'b0;
      step();
      check("rr_resume_src", 32'(out_src), 32'd2);
      check("rr_resume_valid", 32'(out_valid), 32'd1);

      // Asynchronous reset mid-cycle while holding a word
      out_ready = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      check("midrst_valid", 32'(out_valid), 32'd0);
      check("midrst_src",   32'(out_src),   32'd0);
      check("midrst_data",  32'(out_data),  32'd0);
      check("midrst_ready", 32'(in_ready),  32'd0);
      @(negedge clk);
      reset     = 1'b0;
      out_ready = 1'b1;
      #1;
      check("midrst_restart_ready", 32'(in_ready), 32'h1);
      step();
      check("midrst_restart_src",  32'(out_src),  32'd0);
      check("midrst_restart_data", 32'(out_data), 32'h10);

      // Three-input instance: out-of-range forced select
      in_valid3 = 3'b111;
      step();
      check("oor_first_src",   32'(out_src3),   32'd0);
      check("oor_first_data",  32'(out_data3),  32'h20);
      mode3      = 1'b1;
      force_sel3 = 2'd3;
      out_ready3 = 1'b0;
      #1;
      check("oor_ready_stall", 32'(in_ready3), 32'd0);
      step();
      check("oor_hold_valid", 32'(out_valid3), 32'd1);
      out_ready3 = 1'b1;
      #1;
      check("oor_ready_drain", 32'(in_ready3), 32'd0);
      step();
      check("oor_drained_valid", 32'(out_valid3), 32'd0);
      step();
      check("oor_idle_ready", 32'(in_ready3),  32'd0);
      check("oor_idle_valid", 32'(out_valid3), 32'd0);
      check("oor_idle_data",  32'(out_data3),  32'h20);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/stream_mux_rr.md
# stream_mux_rr

Parametrised N-input stream multiplexer with valid/ready handshaking, selectable round-robin or forced-select arbitration, and a registered one-entry output stage. It generalises the team's fixed-width 2:1/3:1 select muxes into a flow-controlled block. It sits between multiple producer stages (fetch, operand, I/O sources) and a single consumer. It reports which source each output word came from.

## Interface
- DATA_WIDTH, 11, width of each data word
- NUM_INPUTS, 4, number of input channels (2..16)
- SEL_WIDTH, $clog2(NUM_INPUTS), derived, width of select/source fields; not overridden
- clk  input  1  sole clock, rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- in_data  input  NUM_INPUTS*DATA_WIDTH  channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- in_valid  input  NUM_INPUTS  channel i presents a word
- in_ready  output  NUM_INPUTS  channel i word is accepted this cycle
- mode  input  1  0 = round-robin arbitration, 1 = forced select
- force_sel  input  SEL_WIDTH  channel index used when mode = 1
- out_data  output  DATA_WIDTH  registered output word
- out_valid  output  1  out_data holds an undelivered word
- out_ready  input  1  consumer accepts out_data this cycle
- out_src  output  SEL_WIDTH  index of channel that supplied out_data

## Operation
- State: output register (out_data, out_src, out_valid), last_grant pointer (SEL_WIDTH bits).
- can_load = !out_valid || out_ready (pass-through ready; empty or draining this cycle).
- Grant (combinational, same cycle):
  - mode 0: first i with in_valid[i], searching from (last_grant+1) mod NUM_INPUTS upward, wrapping; no grant if no valid.
  - mode 1: grant force_sel if force_sel < NUM_INPUTS and in_valid[force_sel]; otherwise no grant. Other channels stall.
- in_ready[i] = can_load && grant_exists && grant == i. At most one bit set. in_ready never depends on in_valid of a non-granted channel beyond arbitration.
- Load (grant exists and can_load): out_data <= granted word, out_src <= grant, out_valid <= 1, last_grant <= grant (both modes).
- Drain without load (out_valid && out_ready, no grant): out_valid <= 0; out_data and out_src hold.
- Stall (out_valid && !out_ready): out_data, out_src, out_valid, last_grant all hold; all in_ready = 0.
- Mode or force_sel changes take effect on the same cycle's grant; no flush.

## Timing
- Reset values: out_valid = 0, out_data = 0, out_src = 0, last_grant = NUM_INPUTS-1 (first round-robin priority is channel 0). in_ready follows combinationally (all 0 while reset asserted).
- Latency: word accepted at edge k appears on out_data/out_valid after edge k; 1 cycle.
- Throughput: one word per cycle sustained when out_ready = 1.
- Simultaneous drain and load in one cycle: new word replaces old; out_valid stays 1.
- Round-robin wrap: after grant to NUM_INPUTS-1, search begins at 0.
- Single requester in mode 0 is granted every cycle (no bubble).
- Reset asserted mid-transfer: word in output register is discarded; in-flight handshake is void; state returns to reset values asynchronously.
- Non-power-of-two NUM_INPUTS: indices >= NUM_INPUTS never granted.

## Test plan
- Reset: assert reset with in_valid = 4'b1111 -> out_valid = 0, out_data = 0, out_src = 0, in_ready = 0; after release and out_ready = 1, first accepted channel is 0.
- Round-robin fairness: NUM_INPUTS = 4, all valid, out_ready = 1, data = 0x10+i -> out_src sequence 0,1,2,3,0 with out_data 0x10,0x11,0x12,0x13,0x10, one per cycle.
- Backpressure: out_valid = 1 holding 0x2A, out_ready = 0 for 3 cycles -> out_data stays 0x2A, in_ready = 0; raise out_ready -> next word loads same edge, out_valid stays 1.
- Forced mode: mode = 1, force_sel = 2, channels 0..3 valid -> only channel 2 ever accepted; set force_sel = 1 -> channel 1 accepted next cycle.
- Out-of-range forced select: NUM_INPUTS = 3, mode = 1, force_sel = 3 -> in_ready = 0 always; out_valid drains to 0 after current word delivered.
- Reset mid-operation: reset pulsed while out_valid = 1, out_src = 2 -> out_valid = 0 immediately; after release, round-robin restarts at channel 0.
